// File: rtl/reorder_buffer_p.sv
// Reorder buffer: allocates tags at dispatch, captures CDB results, retires in program order.
// Latency: a retirement registers one cycle after the head's done bit; at most one retirement per cycle.
// Backpressure: disp_ready drops when full or a mispredict sits at the head; stores wait on st_ack; rdy low freezes all state.
module reorder_buffer_p #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [1:0]        disp_type,
    input  logic [RD_W-1:0]   disp_rd,
    input  logic [DATA_W-1:0] disp_pc,
    input  logic              disp_pred_taken,
    output logic [TAG_W-1:0]  disp_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_value,
    input  logic [DATA_W-1:0] wb_addr,
    input  logic              wb_taken,
    input  logic [TAG_W-1:0]  q_tag,
    output logic              q_ready,
    output logic [DATA_W-1:0] q_value,
    output logic              cmt_valid,
    output logic [RD_W-1:0]   cmt_rd,
    output logic [DATA_W-1:0] cmt_value,
    output logic [TAG_W-1:0]  cmt_tag,
    output logic              st_req,
    output logic [DATA_W-1:0] st_addr,
    output logic [DATA_W-1:0] st_data,
    input  logic              st_ack,
    output logic              flush,
    output logic [DATA_W-1:0] flush_pc,
    output logic [TAG_W:0]    count,
    output logic              empty,
    output logic              full
);

    localparam logic [1:0]     T_ALU     = 2'd0;
    localparam logic [1:0]     T_LOAD    = 2'd1;
    localparam logic [1:0]     T_STORE   = 2'd2;
    localparam logic [1:0]     T_BRANCH  = 2'd3;
    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

    typedef enum logic {S_IDLE, S_ST_WAIT} state_t;

    state_t state, state_nxt;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [TAG_W:0]   head, tail;
    logic [DEPTH-1:0] occ, done;

    logic [1:0]        e_type  [DEPTH];
    logic [RD_W-1:0]   e_rd    [DEPTH];
    logic [DATA_W-1:0] e_pc    [DEPTH];
    logic              e_pred  [DEPTH];
    logic [DATA_W-1:0] e_value [DEPTH];
    logic [DATA_W-1:0] e_addr  [DEPTH];
    logic              e_taken [DEPTH];

    logic [TAG_W-1:0] hidx, tidx;
    logic head_ready, mispredict_at_head, disp_fire, wb_fire;
    logic do_cmt, do_st_start, do_retire, do_flush;

    assign hidx  = head[TAG_W-1:0];
    assign tidx  = tail[TAG_W-1:0];
    assign count = tail - head;
    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    assign head_ready         = occ[hidx] && done[hidx];
    assign mispredict_at_head = (state == S_IDLE) && head_ready &&
                                (e_type[hidx] == T_BRANCH) && (e_taken[hidx] != e_pred[hidx]);

    assign disp_ready = !full && !mispredict_at_head;
    assign disp_tag   = tidx;
    assign disp_fire  = disp_valid && disp_ready && rdy;
    // Results arriving in a flush cycle belong to squashed work and are dropped.
    assign wb_fire    = rdy && wb_valid && occ[wb_tag] && !do_flush;

    // Operand query reads registered entry state only.
    assign q_ready = occ[q_tag] && done[q_tag];
    assign q_value = e_value[q_tag];

    // Commit FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Commit FSM next-state and retirement decisions for the head entry.
    always_comb begin
        state_nxt   = state;
        do_cmt      = 1'b0;
        do_st_start = 1'b0;
        do_retire   = 1'b0;
        do_flush    = 1'b0;
        if (rdy) begin
            case (state)
                S_IDLE: begin
                    if (head_ready) begin
                        case (e_type[hidx])
                            T_ALU, T_LOAD: begin
                                do_cmt    = 1'b1;
                                do_retire = 1'b1;
                            end
                            T_STORE: begin
                                do_st_start = 1'b1;
                                state_nxt   = S_ST_WAIT;
                            end
                            default: begin
                                if (mispredict_at_head) do_flush  = 1'b1;
                                else                    do_retire = 1'b1;
                            end
                        endcase
                    end
                end
                S_ST_WAIT: begin
                    if (st_ack) begin
                        do_retire = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Head/tail pointers; a flush collapses the window to just past the branch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
        end else if (do_flush) begin
            head <= head + 1'b1;
            tail <= head + 1'b1;
        end else begin
            if (do_retire) head <= head + 1'b1;
            if (disp_fire) tail <= tail + 1'b1;
        end
    end

    // Occupied/done flags; retire is applied last so it wins over a late writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ  <= '0;
            done <= '0;
        end else if (do_flush) begin
            occ  <= '0;
            done <= '0;
        end else begin
            if (wb_fire) done[wb_tag] <= 1'b1;
            if (disp_fire) begin
                occ[tidx]  <= 1'b1;
                done[tidx] <= 1'b0;
            end
            if (do_retire) begin
                occ[hidx]  <= 1'b0;
                done[hidx] <= 1'b0;
            end
        end
    end

    // Entry payload; validity is tracked by occ/done so no reset is needed.
    always_ff @(posedge clk) begin
        if (disp_fire) begin
            e_type[tidx] <= disp_type;
            e_rd[tidx]   <= disp_rd;
            e_pc[tidx]   <= disp_pc;
            e_pred[tidx] <= disp_pred_taken;
        end
        if (wb_fire) begin
            e_value[wb_tag] <= wb_value;
            e_addr[wb_tag]  <= wb_addr;
            e_taken[wb_tag] <= wb_taken;
        end
    end

    // Registered retirement outputs: single-cycle pulses plus the held store request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmt_valid <= 1'b0;
            cmt_rd    <= '0;
            cmt_value <= '0;
            cmt_tag   <= '0;
            st_req    <= 1'b0;
            st_addr   <= '0;
            st_data   <= '0;
            flush     <= 1'b0;
            flush_pc  <= '0;
        end else begin
            cmt_valid <= 1'b0;
            flush     <= 1'b0;
            if (do_cmt) begin
                cmt_valid <= 1'b1;
                cmt_rd    <= e_rd[hidx];
                cmt_value <= e_value[hidx];
                cmt_tag   <= hidx;
            end
            if (do_flush) begin
                flush    <= 1'b1;
                flush_pc <= e_taken[hidx] ? e_addr[hidx] : e_pc[hidx] + DATA_W'(4);
            end
            if (do_st_start) begin
                st_req  <= 1'b1;
                st_addr <= e_addr[hidx];
                st_data <= e_value[hidx];
            end else if (state == S_ST_WAIT && do_retire) begin
                st_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_p.sv
// Directed bench for reorder_buffer_p (DEPTH=16).
// Each task drives one scenario and checks outputs 1 time unit after the rising edge.
// Expected values are hand-derived from the commit timing: done at edge N, retire at edge N+1.
module tb_reorder_buffer_p;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        disp_valid, disp_ready, disp_pred_taken;
    logic [1:0]  disp_type;
    logic [4:0]  disp_rd;
    logic [31:0] disp_pc;
    logic [3:0]  disp_tag;
    logic        wb_valid, wb_taken;
    logic [3:0]  wb_tag;
    logic [31:0] wb_value, wb_addr;
    logic [3:0]  q_tag;
    logic        q_ready;
    logic [31:0] q_value;
    logic        cmt_valid;
    logic [4:0]  cmt_rd;
    logic [31:0] cmt_value;
    logic [3:0]  cmt_tag;
    logic        st_req, st_ack;
    logic [31:0] st_addr, st_data;
    logic        flush;
    logic [31:0] flush_pc;
    logic [4:0]  count;
    logic        empty, full;

    int vectors     = 0;
    int miscompares = 0;

    reorder_buffer_p dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_type(disp_type),
        .disp_rd(disp_rd), .disp_pc(disp_pc), .disp_pred_taken(disp_pred_taken),
        .disp_tag(disp_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_addr(wb_addr),
        .wb_taken(wb_taken),
        .q_tag(q_tag), .q_ready(q_ready), .q_value(q_value),
        .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_value(cmt_value), .cmt_tag(cmt_tag),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack),
        .flush(flush), .flush_pc(flush_pc),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [1:0] ty, input logic [4:0] rd,
                            input logic [31:0] pc, input logic pred);
        disp_valid = 1'b1; disp_type = ty; disp_rd = rd; disp_pc = pc; disp_pred_taken = pred;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic writeback(input logic [3:0] tag, input logic [31:0] val,
                             input logic [31:0] addr, input logic tk);
        wb_valid = 1'b1; wb_tag = tag; wb_value = val; wb_addr = addr; wb_taken = tk;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        vectors++;
        if ({count, empty, full, cmt_valid, st_req, flush, disp_ready} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset: count=%0d empty=%b full=%b cmt=%b st_req=%b flush=%b rdy=%b, want 0 1 0 0 0 0 1",
                     count, empty, full, cmt_valid, st_req, flush, disp_ready);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            disp_valid = 1'b1; disp_type = 2'd0; disp_rd = 5'(i + 1); disp_pc = 32'(i * 4); disp_pred_taken = 1'b0;
            #1;
            vectors++;
            if ({disp_ready, disp_tag} !== {1'b1, 4'(i)}) begin
                miscompares++;
                $display("FAIL fill_tag[%0d]: ready=%b tag=%0d, want 1 %0d", i, disp_ready, disp_tag, i);
            end
            @(posedge clk); #1;
        end
        disp_valid = 1'b0;
        vectors++;
        if ({full, disp_ready, count} !== {1'b1, 1'b0, 5'd16}) begin
            miscompares++;
            $display("FAIL fill_full: full=%b ready=%b count=%0d, want 1 0 16", full, disp_ready, count);
        end
    endtask

    task automatic test_out_of_order();
        writeback(4'd1, 32'hA, 32'h0, 1'b0);
        q_tag = 4'd1;
        #1;
        vectors++;
        if ({q_ready, q_value} !== {1'b1, 32'hA}) begin
            miscompares++;
            $display("FAIL query_tag1: ready=%b value=%0h, want 1 a", q_ready, q_value);
        end
        q_tag = 4'd0;
        #1;
        vectors++;
        if (q_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL query_tag0: ready=%b, want 0", q_ready);
        end
        writeback(4'd0, 32'hB, 32'h0, 1'b0);
        tick();
        vectors++;
        if ({cmt_valid, cmt_tag, cmt_value, cmt_rd} !== {1'b1, 4'd0, 32'hB, 5'd1}) begin
            miscompares++;
            $display("FAIL commit_tag0: v=%b tag=%0d val=%0h rd=%0d, want 1 0 b 1", cmt_valid, cmt_tag, cmt_value, cmt_rd);
        end
        tick();
        vectors++;
        if ({cmt_valid, cmt_tag, cmt_value, count, full} !== {1'b1, 4'd1, 32'hA, 5'd14, 1'b0}) begin
            miscompares++;
            $display("FAIL commit_tag1: v=%b tag=%0d val=%0h count=%0d full=%b, want 1 1 a 14 0",
                     cmt_valid, cmt_tag, cmt_value, count, full);
        end
        for (int t = 2; t < 16; t++) begin
            writeback(4'(t), 32'h100 + 32'(t), 32'h0, 1'b0);
            tick();
            vectors++;
            if ({cmt_valid, cmt_tag, cmt_value, cmt_rd} !== {1'b1, 4'(t), 32'h100 + 32'(t), 5'(t + 1)}) begin
                miscompares++;
                $display("FAIL drain_commit[%0d]: v=%b tag=%0d val=%0h rd=%0d", t, cmt_valid, cmt_tag, cmt_value, cmt_rd);
            end
        end
        vectors++;
        if ({empty, count} !== {1'b1, 5'd0}) begin
            miscompares++;
            $display("FAIL drain_empty: empty=%b count=%0d, want 1 0", empty, count);
        end
    endtask

    task automatic test_store();
        dispatch(2'd2, 5'd0, 32'h500, 1'b0);
        st_ack = 1'b0;
        writeback(4'd0, 32'h55, 32'h1000, 1'b0);
        tick();
        vectors++;
        if ({st_req, st_addr, st_data, cmt_valid} !== {1'b1, 32'h1000, 32'h55, 1'b0}) begin
            miscompares++;
            $display("FAIL store_req: req=%b addr=%0h data=%0h cmt=%b, want 1 1000 55 0", st_req, st_addr, st_data, cmt_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({st_req, st_addr, st_data, count, cmt_valid} !== {1'b1, 32'h1000, 32'h55, 5'd1, 1'b0}) begin
                miscompares++;
                $display("FAIL store_hold[%0d]: req=%b addr=%0h data=%0h count=%0d cmt=%b", k, st_req, st_addr, st_data, count, cmt_valid);
            end
        end
        st_ack = 1'b1;
        tick();
        st_ack = 1'b0;
        vectors++;
        if ({st_req, count, cmt_valid} !== {1'b0, 5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL store_ack: req=%b count=%0d cmt=%b, want 0 0 0", st_req, count, cmt_valid);
        end
    endtask

    task automatic test_branch();
        dispatch(2'd3, 5'd0, 32'h200, 1'b0);
        dispatch(2'd0, 5'd2, 32'h204, 1'b0);
        dispatch(2'd0, 5'd3, 32'h208, 1'b0);
        dispatch(2'd0, 5'd4, 32'h20C, 1'b0);
        vectors++;
        if (count !== 5'd4) begin
            miscompares++;
            $display("FAIL branch_count: count=%0d, want 4", count);
        end
        writeback(4'd1, 32'h0, 32'h400, 1'b1);
        vectors++;
        if (disp_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL branch_block: disp_ready=%b, want 0", disp_ready);
        end
        tick();
        vectors++;
        if ({flush, flush_pc, count, empty, cmt_valid} !== {1'b1, 32'h400, 5'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL flush_taken: flush=%b pc=%0h count=%0d empty=%b cmt=%b, want 1 400 0 1 0",
                     flush, flush_pc, count, empty, cmt_valid);
        end
        tick();
        vectors++;
        if (flush !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_pulse: flush=%b, want 0", flush);
        end
        writeback(4'd3, 32'h33, 32'h0, 1'b0);
        q_tag = 4'd3;
        tick();
        vectors++;
        if ({q_ready, cmt_valid, count} !== {1'b0, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL stale_wb: q_ready=%b cmt=%b count=%0d, want 0 0 0", q_ready, cmt_valid, count);
        end
        dispatch(2'd3, 5'd0, 32'h300, 1'b1);
        writeback(4'd2, 32'h0, 32'h999, 1'b0);
        tick();
        vectors++;
        if ({flush, flush_pc, count} !== {1'b1, 32'h304, 5'd0}) begin
            miscompares++;
            $display("FAIL flush_fallthru: flush=%b pc=%0h count=%0d, want 1 304 0", flush, flush_pc, count);
        end
        tick();
    endtask

    // Head index is 3 on entry. Dispatch at edge i, writeback at i+1, retire at i+2.
    task automatic test_wrap();
        int d, c;
        for (int i = 0; i < 50; i++) begin
            disp_valid = (i < 48); disp_type = 2'd0; disp_rd = 5'(i); disp_pc = 32'(i);
            wb_valid = (i >= 1 && i <= 48); wb_tag = 4'(3 + i - 1);
            wb_value = 32'h1000 + 32'(i - 1); wb_addr = 32'h0; wb_taken = 1'b0;
            #1;
            if (i < 48) begin
                vectors++;
                if ({disp_ready, disp_tag} !== {1'b1, 4'(3 + i)}) begin
                    miscompares++;
                    $display("FAIL wrap_tag[%0d]: ready=%b tag=%0d, want 1 %0d", i, disp_ready, disp_tag, (3 + i) % 16);
                end
            end
            @(posedge clk); #1;
            d = (i + 1 < 48) ? i + 1 : 48;
            c = (i >= 2) ? ((i - 1 < 48) ? i - 1 : 48) : 0;
            vectors++;
            if ({count, full, empty} !== {5'(d - c), 1'b0, (d == c)}) begin
                miscompares++;
                $display("FAIL wrap_count[%0d]: count=%0d full=%b empty=%b, want %0d 0 %b", i, count, full, empty, d - c, d == c);
            end
            vectors++;
            if (i >= 2) begin
                if ({cmt_valid, cmt_tag, cmt_value} !== {1'b1, 4'(3 + i - 2), 32'h1000 + 32'(i - 2)}) begin
                    miscompares++;
                    $display("FAIL wrap_commit[%0d]: v=%b tag=%0d val=%0h", i, cmt_valid, cmt_tag, cmt_value);
                end
            end else if (cmt_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_commit[%0d]: v=%b, want 0", i, cmt_valid);
            end
        end
        disp_valid = 1'b0;
        wb_valid   = 1'b0;
    endtask

    task automatic test_rdy_stall();
        dispatch(2'd0, 5'd7, 32'h600, 1'b0);
        writeback(4'd3, 32'h77, 32'h0, 1'b0);
        rdy = 1'b0;
        disp_valid = 1'b1; disp_type = 2'd0; disp_rd = 5'd8;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if ({cmt_valid, count} !== {1'b0, 5'd1}) begin
                miscompares++;
                $display("FAIL rdy_freeze[%0d]: cmt=%b count=%0d, want 0 1", k, cmt_valid, count);
            end
        end
        disp_valid = 1'b0;
        rdy = 1'b1;
        tick();
        vectors++;
        if ({cmt_valid, cmt_tag, cmt_value, cmt_rd, count} !== {1'b1, 4'd3, 32'h77, 5'd7, 5'd0}) begin
            miscompares++;
            $display("FAIL rdy_resume: v=%b tag=%0d val=%0h rd=%0d count=%0d, want 1 3 77 7 0",
                     cmt_valid, cmt_tag, cmt_value, cmt_rd, count);
        end
    endtask

    initial begin
        rdy = 1'b1; disp_valid = 1'b0; disp_type = 2'd0; disp_rd = '0; disp_pc = '0; disp_pred_taken = 1'b0;
        wb_valid = 1'b0; wb_tag = '0; wb_value = '0; wb_addr = '0; wb_taken = 1'b0;
        q_tag = '0; st_ack = 1'b0;
        test_reset();
        test_fill();
        test_out_of_order();
        test_store();
        test_branch();
        test_wrap();
        test_rdy_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reorder_buffer_p.md
Name: reorder_buffer_p

Overview:
Parametrised reorder buffer for the out-of-order core.
- Allocates tags at dispatch, captures results from the common data bus, and retires strictly in program order.
- Retirement drives register-file commit, a store-release handshake to the memory controller, and a branch-mispredict flush with redirect PC.
- Adds over the previous generation: configurable depth and data width, explicit occupancy and status outputs, operand-query bypass, and an acknowledged store-commit protocol.

Parameters:
DEPTH, 16, number of entries; power of two, 4..64
TAG_W, 4, log2(DEPTH)
DATA_W, 32, data/address width
RD_W, 5, architectural register index width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
rdy  in  1  global enable; all state frozen when low
disp_valid  in  1  dispatch request
disp_ready  out  1  entry available; dispatch accepted when disp_valid&disp_ready&rdy
disp_type  in  2  0=ALU/JAL, 1=LOAD, 2=STORE, 3=BRANCH
disp_rd  in  RD_W  destination register
disp_pc  in  DATA_W  instruction PC
disp_pred_taken  in  1  predictor decision (BRANCH only)
disp_tag  out  TAG_W  tag allocated to the accepted dispatch (= tail index)
wb_valid  in  1  CDB result valid
wb_tag  in  TAG_W  producing entry
wb_value  in  DATA_W  result, or store data
wb_addr  in  DATA_W  store address, or branch target
wb_taken  in  1  resolved branch direction
q_tag  in  TAG_W  operand query tag
q_ready  out  1  queried entry occupied and done (combinational)
q_value  out  DATA_W  queried entry value (combinational)
cmt_valid  out  1  one-cycle register commit pulse
cmt_rd  out  RD_W  committed destination
cmt_value  out  DATA_W  committed value
cmt_tag  out  TAG_W  committed tag
st_req  out  1  store release request
st_addr  out  DATA_W  store address
st_data  out  DATA_W  store data
st_ack  in  1  memory controller accepted the store
flush  out  1  one-cycle mispredict flush pulse
flush_pc  out  DATA_W  redirect PC
count  out  TAG_W+1  occupancy
empty  out  1  count==0
full  out  1  count==DEPTH

Behaviour:
- Reset (rst low, async): all outputs 0; head=tail=0; all entries unoccupied and not done; FSM=IDLE.
- Pointers: head/tail are TAG_W+1 bits, with the low TAG_W bits as the index and the MSB as the wrap bit. count = tail - head.
- disp_ready = !full && !mispredict_at_head. It is combinational and does not depend on disp_valid.
- Dispatch (accepted): writes the entry at tail[TAG_W-1:0] with occupied=1 and done=0; tail+1. disp_tag is valid in the same cycle.
- Writeback: on wb_valid and occupied[wb_tag], latch value/addr/taken and set done=1 at the edge. Writeback to an unoccupied tag is ignored.
- q_value/q_ready see the registered entry only; there is no same-cycle bypass from wb.
- Commit FSM, evaluated only when rdy=1 and the head entry is occupied and done:
  - IDLE, ALU/LOAD: next edge cmt_valid=1 with rd/value/tag; head+1; entry freed. rd=0 still pulses (the regfile ignores x0).
  - IDLE, STORE: raise st_req with addr/data; go to ST_WAIT.
  - ST_WAIT: hold st_req and payload stable until a cycle with st_ack=1; at that edge drop st_req, head+1, back to IDLE. No cmt_valid for stores.
  - IDLE, BRANCH, correct prediction (taken==pred_taken): head+1; no cmt_valid.
  - IDLE, BRANCH, mispredict: at the edge, flush=1 for exactly one cycle.
    - flush_pc = taken ? wb_addr : pc+4, mod 2^DATA_W.
    - All entries unoccupied; head=tail=head+1; count=0.
- Commit throughput: at most one retirement per cycle. Commit latency is 1 cycle after the head's done bit is registered.
- Simultaneous events:
  - Dispatch+retire in one cycle: count unchanged; the full→not-full transition takes effect the cycle after retire.
  - Writeback in a flush cycle: discarded.
  - Dispatch in a mispredict-retire cycle: impossible, since disp_ready=0.
- Wrap-around: the index wraps modulo DEPTH and the wrap bit toggles. full and empty are distinguished by the wrap bit.
- rdy low: no state changes. cmt_valid and flush are forced 0. st_req and its payload are held; an st_ack while rdy=0 is not consumed.
- Async reset mid-ST_WAIT: st_req drops immediately and the store is abandoned.

Test Plan:
1. Reset, then dispatch 16 ALU ops (DEPTH=16) -> tags 0..15, full=1 and disp_ready=0 after the 16th; count=16.
2. Write back tags 1,0 out of order (values 0xA,0xB) -> cmt_valid for tag0 (0xB) then tag1 (0xA) on consecutive cycles; empty=1 after the last retirement.
3. STORE at head with wb_addr=0x1000, wb_value=0x55; st_ack held low 3 cycles -> st_req stays high with stable payload; retires on the ack edge; no cmt_valid.
4. BRANCH pc=0x200, pred_taken=0, wb_taken=1, wb_addr=0x400, with 3 younger entries -> single-cycle flush, flush_pc=0x400, count=0; a later writeback to a younger tag is ignored.
5. Fill/drain 3×DEPTH ops with continuous dispatch+commit -> wrap bit toggles, count correct every cycle, no spurious full/empty.
6. Drop rdy for 2 cycles while head is done -> no commit and no state change; commit occurs on the first cycle after rdy returns.
